// File: rtl/fsk_frame_serializer_pkg.sv
// Shared constants, state encoding and CRC helper for the FSK frame serializer.
// The CRC state and helper exist only when FSK_FRAME_CRC8_EN is defined.
package fsk_frame_serializer_pkg;

    localparam logic [7:0]  PREAMBLE_BYTE = 8'h55;
    localparam logic [7:0]  CRC8_POLY     = 8'h07;
    localparam logic [15:0] MIN_BAUD_DIV  = 16'd2;

    typedef enum logic [2:0] {
        StIdle,
        StPre,
        StSync,
        StData,
`ifdef FSK_FRAME_CRC8_EN
        StCrc,
`endif
        StDone
    } fsk_state_e;

    function automatic logic state_busy(input fsk_state_e s);
        logic b;
        b = (s == StPre) || (s == StSync) || (s == StData);
`ifdef FSK_FRAME_CRC8_EN
        b = b || (s == StCrc);
`endif
        return b;
    endfunction

`ifdef FSK_FRAME_CRC8_EN
    // MSB-first CRC-8 update, one whole byte per call.
    function automatic logic [7:0] crc8_update(input logic [7:0] crc, input logic [7:0] data);
        logic [7:0] c;
        c = crc ^ data;
        for (int i = 0; i < 8; i++) begin
            c = c[7] ? ((c << 1) ^ CRC8_POLY) : (c << 1);
        end
        return c;
    endfunction
`endif

endpackage

// File: rtl/fsk_baud_gen.sv
// Bit-period counter: strobe on the first cycle of each bit, last on its final cycle.
// div must be at least 2; the caller clamps it.
module fsk_baud_gen (
    input  logic        bb_clk,
    input  logic        rst,
    input  logic        en,
    input  logic [15:0] div,
    output logic        strobe,
    output logic        last
);

    logic [15:0] cnt_q;

    assign strobe = en && (cnt_q == 16'd0);
    assign last   = en && (cnt_q == div - 16'd1);

    always_ff @(posedge bb_clk or posedge rst) begin
        if (rst) begin
            cnt_q <= 16'd0;
        end else if (!en || last) begin
            cnt_q <= 16'd0;
        end else begin
            cnt_q <= cnt_q + 16'd1;
        end
    end

endmodule

// File: rtl/fsk_frame_serializer.sv
// Frame serializer: preamble, sync word, payload and (with FSK_FRAME_CRC8_EN) a CRC-8 byte,
// sent MSB first with each bit held for max(baud_div,2) bb_clk cycles.
module fsk_frame_serializer
    import fsk_frame_serializer_pkg::*;
#(
    parameter int unsigned PRE_BYTES  = 4,
    parameter logic [15:0] SYNC_WORD  = 16'h2DD4,
    parameter int unsigned SYNC_BITS  = 16,
    parameter logic        IDLE_LEVEL = 1'b0
) (
    input  logic        bb_clk,
    input  logic        rst,
    input  logic [15:0] baud_div,
    input  logic [7:0]  pay_len,
    input  logic        start,
    input  logic [7:0]  din,
    input  logic        din_valid,
    output logic        din_ready,
    output logic        bit_out,
    output logic        bit_strobe,
    output logic        busy,
    output logic        frame_done,
    output logic        underrun
);

    localparam logic [15:0] SyncAligned = SYNC_WORD << (16 - SYNC_BITS);
    localparam logic [7:0]  SyncLen     = 8'(SYNC_BITS);
    localparam logic [7:0]  PreLast     = 8'(PRE_BYTES - 1);

    fsk_state_e  state_q, state_d;
    logic [15:0] div_q, div_d;
    logic [7:0]  len_q, len_d;
    logic [15:0] shift_q, shift_d;
    logic        out_q, out_d;
    logic [2:0]  bit_idx_q, bit_idx_d;
    logic [7:0]  byte_cnt_q, byte_cnt_d;
    logic [7:0]  hold_q, hold_d;
    logic        hold_full_q, hold_full_d;
    logic [7:0]  acc_cnt_q, acc_cnt_d;
    logic        underrun_q, underrun_d;
`ifdef FSK_FRAME_CRC8_EN
    logic [7:0]  crc_q, crc_d;
`endif

    logic        baud_last;
    logic        xfer;
    logic        next_bit, fetch, pay_end;
    logic [7:0]  byte_next;

    fsk_baud_gen u_baud_gen (
        .bb_clk (bb_clk),
        .rst    (rst),
        .en     (busy),
        .div    (div_q),
        .strobe (bit_strobe),
        .last   (baud_last)
    );

    assign busy       = state_busy(state_q);
    assign din_ready  = busy && !hold_full_q && (acc_cnt_q < len_q);
    assign xfer       = din_valid && din_ready;
    assign bit_out    = out_q;
    assign frame_done = (state_q == StDone);
    assign underrun   = underrun_q;

    // Decisions are taken on the last cycle of a bit so the next bit is registered
    // onto bit_out exactly on the following strobe cycle.
    always_comb begin
        state_d     = state_q;
        div_d       = div_q;
        len_d       = len_q;
        shift_d     = shift_q;
        out_d       = out_q;
        bit_idx_d   = bit_idx_q;
        byte_cnt_d  = byte_cnt_q;
        hold_d      = hold_q;
        hold_full_d = hold_full_q;
        acc_cnt_d   = acc_cnt_q;
        underrun_d  = 1'b0;
`ifdef FSK_FRAME_CRC8_EN
        crc_d       = crc_q;
`endif
        next_bit    = 1'b0;
        fetch       = 1'b0;
        pay_end     = 1'b0;
        byte_next   = byte_cnt_q + 8'd1;

        if (xfer) begin
            hold_d      = din;
            hold_full_d = 1'b1;
            acc_cnt_d   = acc_cnt_q + 8'd1;
        end

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    state_d     = StPre;
                    div_d       = (baud_div < MIN_BAUD_DIV) ? MIN_BAUD_DIV : baud_div;
                    len_d       = pay_len;
                    out_d       = PREAMBLE_BYTE[7];
                    shift_d     = {PREAMBLE_BYTE[6:0], 9'd0};
                    bit_idx_d   = 3'd0;
                    byte_cnt_d  = 8'd0;
                    acc_cnt_d   = 8'd0;
                    hold_full_d = 1'b0;
`ifdef FSK_FRAME_CRC8_EN
                    crc_d       = 8'd0;
`endif
                end
            end
            StPre: begin
                if (baud_last) begin
                    if (bit_idx_q != 3'd7) begin
                        next_bit = 1'b1;
                    end else if (byte_cnt_q == PreLast) begin
                        state_d    = StSync;
                        out_d      = SyncAligned[15];
                        shift_d    = SyncAligned << 1;
                        byte_cnt_d = 8'd1;
                    end else begin
                        out_d      = PREAMBLE_BYTE[7];
                        shift_d    = {PREAMBLE_BYTE[6:0], 9'd0};
                        bit_idx_d  = 3'd0;
                        byte_cnt_d = byte_next;
                    end
                end
            end
            StSync: begin
                // byte_cnt counts sync bits here, payload bytes in StData
                if (baud_last) begin
                    if (byte_cnt_q != SyncLen) begin
                        next_bit   = 1'b1;
                        byte_cnt_d = byte_next;
                    end else if (len_q == 8'd0) begin
                        pay_end = 1'b1;
                    end else begin
                        fetch     = 1'b1;
                        byte_next = 8'd1;
                    end
                end
            end
            StData: begin
                if (baud_last) begin
                    if (bit_idx_q != 3'd7) begin
                        next_bit = 1'b1;
                    end else if (byte_cnt_q == len_q) begin
                        pay_end = 1'b1;
                    end else begin
                        fetch = 1'b1;
                    end
                end
            end
`ifdef FSK_FRAME_CRC8_EN
            StCrc: begin
                if (baud_last) begin
                    if (bit_idx_q != 3'd7) begin
                        next_bit = 1'b1;
                    end else begin
                        state_d = StDone;
                        out_d   = IDLE_LEVEL;
                    end
                end
            end
`endif
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
                out_d   = IDLE_LEVEL;
            end
        endcase

        if (next_bit) begin
            out_d     = shift_q[15];
            shift_d   = shift_q << 1;
            bit_idx_d = bit_idx_q + 3'd1;
        end

        if (pay_end) begin
`ifdef FSK_FRAME_CRC8_EN
            state_d   = StCrc;
            out_d     = crc_q[7];
            shift_d   = {crc_q[6:0], 9'd0};
            bit_idx_d = 3'd0;
`else
            state_d   = StDone;
            out_d     = IDLE_LEVEL;
`endif
        end

        if (fetch) begin
            if (hold_full_q) begin
                state_d     = StData;
                out_d       = hold_q[7];
                shift_d     = {hold_q[6:0], 9'd0};
                bit_idx_d   = 3'd0;
                byte_cnt_d  = byte_next;
                hold_full_d = 1'b0;
`ifdef FSK_FRAME_CRC8_EN
                crc_d       = crc8_update(crc_q, hold_q);
`endif
            end else begin
                state_d     = StIdle;
                out_d       = IDLE_LEVEL;
                underrun_d  = 1'b1;
                hold_full_d = 1'b0;
            end
        end
    end

    always_ff @(posedge bb_clk or posedge rst) begin
        if (rst) begin
            state_q     <= StIdle;
            div_q       <= MIN_BAUD_DIV;
            len_q       <= 8'd0;
            shift_q     <= 16'd0;
            out_q       <= IDLE_LEVEL;
            bit_idx_q   <= 3'd0;
            byte_cnt_q  <= 8'd0;
            hold_q      <= 8'd0;
            hold_full_q <= 1'b0;
            acc_cnt_q   <= 8'd0;
            underrun_q  <= 1'b0;
`ifdef FSK_FRAME_CRC8_EN
            crc_q       <= 8'd0;
`endif
        end else begin
            state_q     <= state_d;
            div_q       <= div_d;
            len_q       <= len_d;
            shift_q     <= shift_d;
            out_q       <= out_d;
            bit_idx_q   <= bit_idx_d;
            byte_cnt_q  <= byte_cnt_d;
            hold_q      <= hold_d;
            hold_full_q <= hold_full_d;
            acc_cnt_q   <= acc_cnt_d;
            underrun_q  <= underrun_d;
`ifdef FSK_FRAME_CRC8_EN
            crc_q       <= crc_d;
`endif
        end
    end

endmodule

// File: tb/tb_fsk_frame_serializer.sv
// Self-checking bench for fsk_frame_serializer: each frame is compared against a bit list
// built from the frame definition, plus bit timing, handshake and abort behaviour.
module tb_fsk_frame_serializer;

    localparam int unsigned PreBytes  = 4;
    localparam int unsigned SyncBits  = 16;
    localparam logic [15:0] SyncWord  = 16'h2DD4;
    localparam logic        IdleLevel = 1'b0;

    // Run modes for run_frame
    localparam int ModeNormal   = 0;
    localparam int ModeRestart  = 1;
    localparam int ModeReset    = 2;
    localparam int ModeUnderrun = 3;

    logic        bb_clk;
    logic        rst;
    logic [15:0] baud_div;
    logic [7:0]  pay_len;
    logic        start;
    logic [7:0]  din;
    logic        din_valid;
    logic        din_ready;
    logic        bit_out;
    logic        bit_strobe;
    logic        busy;
    logic        frame_done;
    logic        underrun;

    int n_checks;
    int n_errors;
    int cyc;

    logic [7:0] pay[$];
    logic       exp_bits[$];
    logic       got_bits[$];

    fsk_frame_serializer #(
        .PRE_BYTES  (PreBytes),
        .SYNC_WORD  (SyncWord),
        .SYNC_BITS  (SyncBits),
        .IDLE_LEVEL (IdleLevel)
    ) dut (
        .bb_clk     (bb_clk),
        .rst        (rst),
        .baud_div   (baud_div),
        .pay_len    (pay_len),
        .start      (start),
        .din        (din),
        .din_valid  (din_valid),
        .din_ready  (din_ready),
        .bit_out    (bit_out),
        .bit_strobe (bit_strobe),
        .busy       (busy),
        .frame_done (frame_done),
        .underrun   (underrun)
    );

    initial bb_clk = 1'b0;
    always #5 bb_clk = ~bb_clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got !== want) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, want, cyc);
        end
    endtask

    task automatic tick();
        @(posedge bb_clk);
        #1;
        cyc++;
    endtask

    // CRC-8 as polynomial long division of (payload bits followed by 8 zeros) by x^8+x^2+x+1
    function automatic logic [7:0] crc_ref();
        logic       m [0:255];
        logic [8:0] poly9;
        logic [7:0] r;
        int         n;
        poly9 = 9'h107;
        n = 0;
        foreach (pay[b]) begin
            for (int i = 7; i >= 0; i--) begin
                m[n] = pay[b][i];
                n++;
            end
        end
        for (int i = 0; i < 8; i++) begin
            m[n] = 1'b0;
            n++;
        end
        for (int i = 0; i + 8 < n; i++) begin
            if (m[i]) begin
                for (int j = 0; j < 9; j++) m[i + j] = m[i + j] ^ poly9[8 - j];
            end
        end
        for (int i = 0; i < 8; i++) r[7 - i] = m[n - 8 + i];
        return r;
    endfunction

    task automatic push_byte(input logic [7:0] v);
        for (int i = 7; i >= 0; i--) exp_bits.push_back(v[i]);
    endtask

    task automatic build_expected();
        exp_bits.delete();
        for (int b = 0; b < int'(PreBytes); b++) push_byte(8'h55);
        for (int i = int'(SyncBits) - 1; i >= 0; i--) exp_bits.push_back(SyncWord[i]);
        foreach (pay[b]) push_byte(pay[b]);
`ifdef FSK_FRAME_CRC8_EN
        push_byte(crc_ref());
`endif
    endtask

    function automatic logic [7:0] got_last_byte();
        logic [7:0] v;
        int         n;
        v = 8'd0;
        n = got_bits.size();
        for (int i = 0; i < 8; i++) v[7 - i] = (n >= 8) ? got_bits[n - 8 + i] : 1'b0;
        return v;
    endfunction

    task automatic fill_random(input int len);
        pay.delete();
        for (int i = 0; i < len; i++) pay.push_back(8'($urandom_range(0, 255)));
    endtask

    task automatic run_frame(input int div, input int mode);
        int p, len, idx, k, last_s, n_hdr, budget, t_mid_sync, t_mid_data;
        bit ended;
        p          = (div < 2) ? 2 : div;
        len        = pay.size();
        n_hdr      = 8 * int'(PreBytes) + int'(SyncBits);
        t_mid_sync = p * (8 * int'(PreBytes) + int'(SyncBits) / 2) + 1;
        t_mid_data = p * (n_hdr + 4) + 1;
        idx        = 0;
        k          = 0;
        last_s     = 0;
        ended      = 1'b0;
        build_expected();
        got_bits.delete();
        budget     = p * exp_bits.size() + 10;

        baud_div = 16'(div);
        pay_len  = 8'(len);
        start    = 1'b1;
        cyc      = 0;
        tick();
        start    = 1'b0;

        while (!ended && cyc <= budget) begin
            if (underrun) begin
                ended = 1'b1;
                if (mode == ModeUnderrun) begin
                    check_eq("underrun_time", cyc, p * n_hdr + 1);
                    check_eq("underrun_busy", busy, 0);
                    check_eq("underrun_idle", bit_out, IdleLevel);
                    check_eq("underrun_bits", got_bits.size(), n_hdr);
                end else begin
                    check_eq("unexpected_underrun", underrun, 0);
                end
            end else if (frame_done) begin
                ended = 1'b1;
                if (mode == ModeUnderrun) begin
                    check_eq("done_after_underrun", frame_done, 0);
                end else begin
                    check_eq("done_time", cyc, p * exp_bits.size() + 1);
                    check_eq("done_nbits", got_bits.size(), exp_bits.size());
                    check_eq("done_idle", bit_out, IdleLevel);
                    check_eq("done_busy", busy, 0);
                end
            end else if (mode == ModeReset && cyc == t_mid_data) begin
                ended = 1'b1;
                rst   = 1'b1;
                #1;
                check_eq("rst_busy", busy, 0);
                check_eq("rst_idle", bit_out, IdleLevel);
                check_eq("rst_ready", din_ready, 0);
                tick();
                rst = 1'b0;
                check_eq("rst_no_done", frame_done, 0);
                check_eq("rst_no_underrun", underrun, 0);
            end else begin
                if (bit_strobe) begin
                    if (k == 0) check_eq("first_strobe", cyc, 1);
                    else check_eq("bit_period", cyc - last_s, p);
                    if (k < exp_bits.size()) check_eq("bit", bit_out, exp_bits[k]);
                    else check_eq("extra_bits", k, exp_bits.size());
                    got_bits.push_back(bit_out);
                    last_s = cyc;
                    k++;
                end else if (busy && k > 0 && k <= exp_bits.size()) begin
                    check_eq("bit_hold", bit_out, exp_bits[k - 1]);
                end
                if (idx >= len) check_eq("ready_when_all_taken", din_ready, 0);
                start     = (mode == ModeRestart) && (cyc == t_mid_sync);
                din_valid = (mode != ModeUnderrun) && (idx < len) && ($urandom_range(0, 3) != 0);
                din       = (idx < len) ? pay[idx] : 8'h00;
                if (din_valid && din_ready) idx++;
                tick();
            end
        end
        start     = 1'b0;
        din_valid = 1'b0;
        if (!ended) check_eq("frame_timeout_done", frame_done, 1);
        if (mode == ModeUnderrun) begin
            repeat (3) begin
                tick();
                check_eq("no_done_after_underrun", frame_done, 0);
            end
        end else if (mode != ModeReset) begin
            tick();
            check_eq("idle_after_done", busy, 0);
        end
    endtask

    initial begin
        n_checks  = 0;
        n_errors  = 0;
        cyc       = 0;
        rst       = 1'b1;
        baud_div  = 16'd0;
        pay_len   = 8'd0;
        start     = 1'b0;
        din       = 8'd0;
        din_valid = 1'b0;
        repeat (3) tick();
        check_eq("reset_bit_out", bit_out, IdleLevel);
        check_eq("reset_busy", busy, 0);
        check_eq("reset_ready", din_ready, 0);
        check_eq("reset_strobe", bit_strobe, 0);
        check_eq("reset_done", frame_done, 0);
        check_eq("reset_underrun", underrun, 0);
        rst = 1'b0;
        tick();

        // Directed frame with known payload
        pay.delete();
        pay.push_back(8'hA5);
        pay.push_back(8'h3C);
        run_frame(4, ModeNormal);

        // Withheld payload byte
        pay.delete();
        pay.push_back(8'h77);
        run_frame(3, ModeUnderrun);

        // Clamped bit periods
        fill_random(2);
        run_frame(0, ModeNormal);
        fill_random(1);
        run_frame(1, ModeNormal);

        // Extra start during sync
        fill_random(3);
        run_frame(5, ModeRestart);

        // Reset mid-payload, then a clean frame
        fill_random(3);
        run_frame(3, ModeReset);
        fill_random(2);
        run_frame(3, ModeNormal);

        // Empty payload
        pay.delete();
        run_frame(2, ModeNormal);

`ifdef FSK_FRAME_CRC8_EN
        pay.delete();
        for (int i = 0; i < 9; i++) pay.push_back(8'(8'h31 + i));
        run_frame(2, ModeNormal);
        check_eq("crc_check_string", got_last_byte(), 8'hF4);
        pay.delete();
        run_frame(2, ModeNormal);
        check_eq("crc_empty", got_last_byte(), 8'h00);
`endif

        repeat (8) begin
            fill_random(int'($urandom_range(0, 5)));
            run_frame(int'($urandom_range(0, 6)), ModeNormal);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
